// File: rtl/riscv_irq_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_irq_dispatcher_pkg
// Description : Shared definitions for the interrupt dispatcher: interrupt
//               ID width and the dispatcher state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_irq_dispatcher_pkg;

  localparam int IRQ_ID_W = 5;

  typedef enum logic [1:0] {
    IDISP_IDLE = 2'd0,
    IDISP_REQ  = 2'd1,
    IDISP_GAP  = 2'd2
  } irq_disp_state_t;

endpackage
`default_nettype wire

// File: rtl/riscv_irq_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_irq_dispatcher_if
// Description : Level interrupt request / acknowledge link between the
//               dispatcher (master) and the core (slave).
//   irq_o        - level request to the core
//   irq_id_o     - locked interrupt ID
//   irq_sec_o    - secure bit of the locked ID
//   irq_ack_i    - one-cycle acknowledge pulse from the core
//   irq_ack_id_i - ID being acknowledged
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_irq_dispatcher_if;
  import riscv_irq_dispatcher_pkg::*;

  logic                irq_o;
  logic [IRQ_ID_W-1:0] irq_id_o;
  logic                irq_sec_o;
  logic                irq_ack_i;
  logic [IRQ_ID_W-1:0] irq_ack_id_i;

  modport master (
    output irq_o, irq_id_o, irq_sec_o,
    input  irq_ack_i, irq_ack_id_i
  );

  modport slave (
    input  irq_o, irq_id_o, irq_sec_o,
    output irq_ack_i, irq_ack_id_i
  );

endinterface
`default_nettype wire

// File: rtl/riscv_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : riscv_irq_prio_enc
// Description : Combinational highest-set-bit encoder.
//   vec_i   - WIDTH-wide request vector
//   valid_o - at least one bit of vec_i is set
//   idx_o   - index of the highest set bit (zero when none is set)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_irq_prio_enc
  import riscv_irq_dispatcher_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0]    vec_i,
  output logic                     valid_o,
  output logic [IRQ_ID_W-1:0]      idx_o
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IRQ_ID_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_irq_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : riscv_irq_dispatcher
// Description : Captures rising edges on peripheral interrupt lines into a
//               pending register, masks them, and presents the highest
//               pending enabled ID to the core as a level request held until
//               acknowledged, followed by a one-cycle gap.
//   clk, rst               - clock, asynchronous active-high reset
//   irq_lines_i            - peripheral event lines (synchronous to clk)
//   mask_we_i/mask_wdata_i - enable mask write
//   sec_we_i/sec_wdata_i   - secure mask write
//   core (master modport)  - irq / irq_id / irq_sec / ack / ack_id
//   pending_o              - pending register readback
//   ack_err_o              - sticky ack-ID mismatch flag
// Optional    : RISCV_IRQ_DISPATCH_SWSET_EN adds swset_we_i / swset_wdata_i
//               for software setting of pending bits.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_irq_dispatcher
  import riscv_irq_dispatcher_pkg::*;
#(
  parameter int          NUM_IRQ    = 32,
  parameter logic [31:0] RESET_MASK = 32'h0,
  parameter logic [31:0] RESET_SEC  = 32'h0
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [NUM_IRQ-1:0] irq_lines_i,
  input  wire logic               mask_we_i,
  input  wire logic [NUM_IRQ-1:0] mask_wdata_i,
  input  wire logic               sec_we_i,
  input  wire logic [NUM_IRQ-1:0] sec_wdata_i,
`ifdef RISCV_IRQ_DISPATCH_SWSET_EN
  input  wire logic               swset_we_i,
  input  wire logic [NUM_IRQ-1:0] swset_wdata_i,
`endif
  riscv_irq_dispatcher_if.master  core,
  output logic [NUM_IRQ-1:0]      pending_o,
  output logic                    ack_err_o
);

  localparam logic [1:0] S_IDLE = 2'(IDISP_IDLE);
  localparam logic [1:0] S_REQ  = 2'(IDISP_REQ);
  localparam logic [1:0] S_GAP  = 2'(IDISP_GAP);

  logic [1:0]          r_state;
  logic [NUM_IRQ-1:0]  r_pending;
  logic [NUM_IRQ-1:0]  r_mask;
  logic [NUM_IRQ-1:0]  r_sec;
  logic [NUM_IRQ-1:0]  r_lines_q;
  logic                r_armed;
  logic [IRQ_ID_W-1:0] r_id;
  logic                r_sec_q;
  logic                r_ack_err;

  logic [NUM_IRQ-1:0]  w_ack_clr;
  logic [NUM_IRQ-1:0]  w_set;
  logic [NUM_IRQ-1:0]  w_pending_nxt;
  logic                w_cand_valid;
  logic [IRQ_ID_W-1:0] w_cand_idx;
  logic                w_cand_sec;
  logic                w_ack_bad;

  riscv_irq_prio_enc #(
    .WIDTH (NUM_IRQ)
  ) u_prio_enc (
    .vec_i   (r_pending & r_mask),
    .valid_o (w_cand_valid),
    .idx_o   (w_cand_idx)
  );

  always_comb begin
    w_ack_clr  = '0;
    w_cand_sec = 1'b0;
    // Ack IDs at or above NUM_IRQ match no bit here, so they clear nothing.
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_ack_clr[i] = core.irq_ack_i && (core.irq_ack_id_i == IRQ_ID_W'(i));
      if (w_cand_idx == IRQ_ID_W'(i)) begin
        w_cand_sec = r_sec[i];
      end
    end
    // r_armed suppresses capture on the first cycle after reset, so a line
    // already high across reset release is not mistaken for a new event.
    w_set = irq_lines_i & ~r_lines_q & {NUM_IRQ{r_armed}};
`ifdef RISCV_IRQ_DISPATCH_SWSET_EN
    if (swset_we_i) begin
      w_set = w_set | swset_wdata_i;
    end
`endif
    // Set wins over a same-cycle clear of the same bit.
    w_pending_nxt = (r_pending & ~w_ack_clr) | w_set;
    // Any ack outside REQ is an error; in REQ, so is an ID mismatch (which
    // also covers out-of-range IDs since the locked ID is always in range).
    w_ack_bad = core.irq_ack_i &&
                ((r_state != S_REQ) || (core.irq_ack_id_i != r_id));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_mask    <= RESET_MASK[NUM_IRQ-1:0];
      r_sec     <= RESET_SEC[NUM_IRQ-1:0];
      r_lines_q <= '0;
      r_armed   <= 1'b0;
      r_id      <= '0;
      r_sec_q   <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_lines_q <= irq_lines_i;
      r_armed   <= 1'b1;
      r_pending <= w_pending_nxt;
      if (mask_we_i) r_mask <= mask_wdata_i;
      if (sec_we_i)  r_sec  <= sec_wdata_i;
      if (w_ack_bad) r_ack_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_cand_valid) begin
            r_id    <= w_cand_idx;
            r_sec_q <= w_cand_sec;
            r_state <= S_REQ;
          end
        end
        // No preemption and no retraction: only an ack leaves REQ.
        S_REQ: begin
          if (core.irq_ack_i) r_state <= S_GAP;
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core.irq_o     = (r_state == S_REQ);
  assign core.irq_id_o  = r_id;
  assign core.irq_sec_o = r_sec_q;
  assign pending_o      = r_pending;
  assign ack_err_o      = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_riscv_irq_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_irq_dispatcher
// Description : Directed self-checking bench for riscv_irq_dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_irq_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] irq_lines = '0;
  logic        mask_we = 1'b0;
  logic [31:0] mask_wdata = '0;
  logic        sec_we = 1'b0;
  logic [31:0] sec_wdata = '0;
  logic [31:0] pending;
  logic        ack_err;
  int          n_pass = 0;
  int          n_total = 0;

  riscv_irq_dispatcher_if core_if ();

  riscv_irq_dispatcher #(
    .NUM_IRQ    (32),
    .RESET_MASK (32'hFFFF_FFFF),
    .RESET_SEC  (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_lines_i  (irq_lines),
    .mask_we_i    (mask_we),
    .mask_wdata_i (mask_wdata),
    .sec_we_i     (sec_we),
    .sec_wdata_i  (sec_wdata),
`ifdef RISCV_IRQ_DISPATCH_SWSET_EN
    .swset_we_i    (1'b0),
    .swset_wdata_i (32'h0),
`endif
    .core         (core_if.master),
    .pending_o    (pending),
    .ack_err_o    (ack_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [4:0] id);
    core_if.irq_ack_i    = 1'b1;
    core_if.irq_ack_id_i = id;
    step();
    core_if.irq_ack_i    = 1'b0;
    core_if.irq_ack_id_i = '0;
  endtask

  task automatic test_reset();
    step(); step();
    rst = 1'b0;
    step();
    n_total++; if (core_if.irq_o !== 1'b0) $display("FAIL reset_irq got %b want 0", core_if.irq_o); else n_pass++;
    n_total++; if (core_if.irq_id_o !== 5'd0) $display("FAIL reset_id got %0d want 0", core_if.irq_id_o); else n_pass++;
    n_total++; if (core_if.irq_sec_o !== 1'b0) $display("FAIL reset_sec got %b want 0", core_if.irq_sec_o); else n_pass++;
    n_total++; if (pending !== 32'h0) $display("FAIL reset_pending got %h want 0", pending); else n_pass++;
    n_total++; if (ack_err !== 1'b0) $display("FAIL reset_ackerr got %b want 0", ack_err); else n_pass++;
  endtask

  task automatic test_single();
    irq_lines = 32'h8; step(); irq_lines = '0;
    n_total++; if (pending !== 32'h8) $display("FAIL single_pending got %h want 8", pending); else n_pass++;
    n_total++; if (core_if.irq_o !== 1'b0) $display("FAIL single_irq_early got %b want 0", core_if.irq_o); else n_pass++;
    step();
    n_total++; if (core_if.irq_o !== 1'b1) $display("FAIL single_irq got %b want 1", core_if.irq_o); else n_pass++;
    n_total++; if (core_if.irq_id_o !== 5'd3) $display("FAIL single_id got %0d want 3", core_if.irq_id_o); else n_pass++;
    step();
    n_total++; if (core_if.irq_o !== 1'b1) $display("FAIL single_hold got %b want 1", core_if.irq_o); else n_pass++;
    ack(5'd3);
    n_total++; if (core_if.irq_o !== 1'b0) $display("FAIL single_gap got %b want 0", core_if.irq_o); else n_pass++;
    n_total++; if (pending !== 32'h0) $display("FAIL single_clr got %h want 0", pending); else n_pass++;
    step(); step();
    n_total++; if (core_if.irq_o !== 1'b0) $display("FAIL single_stay_low got %b want 0", core_if.irq_o); else n_pass++;
    n_total++; if (ack_err !== 1'b0) $display("FAIL single_ackerr got %b want 0", ack_err); else n_pass++;
  endtask

  task automatic test_priority();
    irq_lines = 32'h204; step(); irq_lines = '0; step();
    n_total++; if (core_if.irq_id_o !== 5'd9 || core_if.irq_o !== 1'b1) $display("FAIL prio_first got irq=%b id=%0d want irq=1 id=9", core_if.irq_o, core_if.irq_id_o); else n_pass++;
    ack(5'd9);
    n_total++; if (pending !== 32'h4 || core_if.irq_o !== 1'b0) $display("FAIL prio_gap got irq=%b pend=%h want irq=0 pend=4", core_if.irq_o, pending); else n_pass++;
    step();
    n_total++; if (core_if.irq_o !== 1'b0) $display("FAIL prio_idle got %b want 0", core_if.irq_o); else n_pass++;
    step();
    n_total++; if (core_if.irq_id_o !== 5'd2 || core_if.irq_o !== 1'b1) $display("FAIL prio_second got irq=%b id=%0d want irq=1 id=2", core_if.irq_o, core_if.irq_id_o); else n_pass++;
    ack(5'd2); step(); step();
  endtask

  task automatic test_no_preempt();
    irq_lines = 32'h20; step(); irq_lines = '0; step();
    irq_lines = 32'h0010_0000; step(); irq_lines = '0; step();
    n_total++; if (core_if.irq_id_o !== 5'd5 || core_if.irq_o !== 1'b1) $display("FAIL nopre_hold got irq=%b id=%0d want irq=1 id=5", core_if.irq_o, core_if.irq_id_o); else n_pass++;
    n_total++; if (pending !== 32'h0010_0020) $display("FAIL nopre_pending got %h want 00100020", pending); else n_pass++;
    ack(5'd5); step(); step();
    n_total++; if (core_if.irq_id_o !== 5'd20 || core_if.irq_o !== 1'b1) $display("FAIL nopre_next got irq=%b id=%0d want irq=1 id=20", core_if.irq_o, core_if.irq_id_o); else n_pass++;
    ack(5'd20); step(); step();
  endtask

  task automatic test_ack_err();
    irq_lines = 32'h10; step(); irq_lines = '0; step();
    irq_lines = 32'h80; step(); irq_lines = '0;
    n_total++; if (core_if.irq_id_o !== 5'd4) $display("FAIL err_locked got %0d want 4", core_if.irq_id_o); else n_pass++;
    ack(5'd7);
    n_total++; if (pending !== 32'h10) $display("FAIL err_pending got %h want 10", pending); else n_pass++;
    n_total++; if (ack_err !== 1'b1) $display("FAIL err_flag got %b want 1", ack_err); else n_pass++;
    n_total++; if (core_if.irq_o !== 1'b0) $display("FAIL err_gap got %b want 0", core_if.irq_o); else n_pass++;
    step(); step();
    n_total++; if (core_if.irq_id_o !== 5'd4 || core_if.irq_o !== 1'b1) $display("FAIL err_rereq got irq=%b id=%0d want irq=1 id=4", core_if.irq_o, core_if.irq_id_o); else n_pass++;
    ack(5'd4); step(); step();
    n_total++; if (ack_err !== 1'b1) $display("FAIL err_sticky got %b want 1", ack_err); else n_pass++;
  endtask

  task automatic test_mask_sec();
    mask_we = 1'b1; mask_wdata = '0; step(); mask_we = 1'b0;
    irq_lines = 32'h1000; step(); irq_lines = '0; step(); step();
    n_total++; if (core_if.irq_o !== 1'b0) $display("FAIL mask_blocked got %b want 0", core_if.irq_o); else n_pass++;
    n_total++; if (pending !== 32'h1000) $display("FAIL mask_pending got %h want 1000", pending); else n_pass++;
    sec_we = 1'b1; sec_wdata = 32'h1000; step(); sec_we = 1'b0;
    mask_we = 1'b1; mask_wdata = 32'h1000; step(); mask_we = 1'b0;
    n_total++; if (core_if.irq_o !== 1'b0) $display("FAIL mask_one_cycle got %b want 0", core_if.irq_o); else n_pass++;
    step();
    n_total++; if (core_if.irq_o !== 1'b1 || core_if.irq_id_o !== 5'd12) $display("FAIL mask_req got irq=%b id=%0d want irq=1 id=12", core_if.irq_o, core_if.irq_id_o); else n_pass++;
    n_total++; if (core_if.irq_sec_o !== 1'b1) $display("FAIL mask_sec got %b want 1", core_if.irq_sec_o); else n_pass++;
    ack(5'd12); step(); step();
  endtask

  task automatic test_reset_mid_req();
    irq_lines = 32'h1000; step(); irq_lines = '0; step();
    n_total++; if (core_if.irq_o !== 1'b1) $display("FAIL rmid_pre got %b want 1", core_if.irq_o); else n_pass++;
    irq_lines = 32'h2;
    #2 rst = 1'b1;
    #1;
    n_total++; if (core_if.irq_o !== 1'b0) $display("FAIL rmid_irq got %b want 0", core_if.irq_o); else n_pass++;
    n_total++; if (pending !== 32'h0 || ack_err !== 1'b0) $display("FAIL rmid_state got pend=%h err=%b want pend=0 err=0", pending, ack_err); else n_pass++;
    step();
    rst = 1'b0;
    step(); step();
    n_total++; if (pending !== 32'h0) $display("FAIL rmid_no_edge got %h want 0", pending); else n_pass++;
    // Line 6 alone fires only if the mask is back to all ones.
    irq_lines = 32'h42; step(); irq_lines = 32'h2; step();
    n_total++; if (core_if.irq_o !== 1'b1 || core_if.irq_id_o !== 5'd6) $display("FAIL rmid_mask got irq=%b id=%0d want irq=1 id=6", core_if.irq_o, core_if.irq_id_o); else n_pass++;
    n_total++; if (pending !== 32'h40) $display("FAIL rmid_pending got %h want 40", pending); else n_pass++;
  endtask

  initial begin
    core_if.irq_ack_i    = 1'b0;
    core_if.irq_ack_id_i = '0;
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_ack_err();
    test_mask_sec();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
